// File: rtl/game_phase_ctrl.sv
// Game phase sequencer: TITLE -> PLAY -> DYING/CLEAR -> PLAY or OVER -> TITLE.
// Handles lives, level, the freeze gate and the respawn / end-of-game pulses.
module game_phase_ctrl #(
  parameter int DEATH_FRAMES = 120,
  parameter int CLEAR_FRAMES = 90,
  parameter int OVER_FRAMES  = 180,
  parameter int LIVES_INIT   = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic       dug_hit_i,
  input  logic       level_clear_i,
  output logic [2:0] phase_o,
  output logic       freeze_o,
  output logic       respawn_o,
  output logic [1:0] lives_o,
  output logic [3:0] level_o,
  output logic       endgame_delay_o
);

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [3:0] LEVEL_MAX  = 4'd15;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic       respawn_q, respawn_d;
  logic       endgame_q, endgame_d;
  logic       timed_state;

  // State register and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_TITLE;
      timer_q   <= 8'd0;
      lives_q   <= 2'd0;
      level_q   <= 4'd0;
      respawn_q <= 1'b0;
      endgame_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      respawn_q <= respawn_d;
      endgame_q <= endgame_d;
    end
  end

  // Next-state logic; inputs not relevant to the current state are ignored
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    unique case (state_q)
      ST_TITLE: begin
        if (start_i) begin
          state_d = ST_PLAY;
          lives_d = LIVES_LOAD;
          level_d = 4'd1;
        end
      end
      ST_PLAY: begin
        if (dug_hit_i) begin
          state_d = ST_DYING;
        end else if (level_clear_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_DYING: begin
        if (frame_tick_i && (timer_q == DEATH_LAST)) begin
          if (lives_q == 2'd1) begin
            state_d = ST_OVER;
            lives_d = 2'd0;
          end else begin
            state_d = ST_PLAY;
            lives_d = lives_q - 2'd1;
          end
        end
      end
      ST_CLEAR: begin
        if (frame_tick_i && (timer_q == CLEAR_LAST)) begin
          state_d = ST_PLAY;
          if (level_q != LEVEL_MAX) begin
            level_d = level_q + 4'd1;
          end
        end
      end
      ST_OVER: begin
        if (frame_tick_i && (timer_q == OVER_LAST)) begin
          state_d = ST_TITLE;
        end
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // Frame timer restarts on every phase change so each timed phase counts from 0
  always_comb begin
    timed_state = (state_q == ST_DYING) || (state_q == ST_CLEAR) || (state_q == ST_OVER);
    timer_d     = timer_q;
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end else if (timed_state && frame_tick_i) begin
      timer_d = timer_q + 8'd1;
    end
  end

  // Output logic: pulses are computed from the transition and registered
  always_comb begin
    respawn_d       = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    endgame_d       = (state_d == ST_OVER) && (state_q != ST_OVER);
    phase_o         = state_q;
    freeze_o        = (state_q != ST_PLAY);
    respawn_o       = respawn_q;
    endgame_delay_o = endgame_q;
    lives_o         = lives_q;
    level_o         = level_q;
  end

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Randomised and directed stimulus for game_phase_ctrl, checked through an
// expected-value queue against a phase/lives/level model of the game rules.
module tb_game_phase_ctrl;

  localparam int DEATH = 4;
  localparam int CLEAR = 3;
  localparam int OVER  = 2;
  localparam int LIVES = 3;
  localparam int W     = 12;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       dug_hit;
  logic       level_clear;
  logic [2:0] phase;
  logic       freeze;
  logic       respawn;
  logic [1:0] lives;
  logic [3:0] level;
  logic       endgame_delay;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int m_phase = 0;
  int m_lives = 0;
  int m_level = 0;
  int m_ticks = 0;
  int m_resp  = 0;
  int m_endg  = 0;

  game_phase_ctrl #(
    .DEATH_FRAMES(DEATH),
    .CLEAR_FRAMES(CLEAR),
    .OVER_FRAMES (OVER),
    .LIVES_INIT  (LIVES)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_tick_i   (frame_tick),
    .start_i        (start),
    .dug_hit_i      (dug_hit),
    .level_clear_i  (level_clear),
    .phase_o        (phase),
    .freeze_o       (freeze),
    .respawn_o      (respawn),
    .lives_o        (lives),
    .level_o        (level),
    .endgame_delay_o(endgame_delay)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack_exp();
    logic [W-1:0] v;
    v = {3'(m_phase), (m_phase != 1) ? 1'b1 : 1'b0, 1'(m_resp), 2'(m_lives), 4'(m_level), 1'(m_endg)};
    return v;
  endfunction

  // Game rules: one call = what the outputs show after the next edge
  task automatic model_step(input logic r, input logic st, input logic hit,
                            input logic clr, input logic tick);
    m_resp = 0;
    m_endg = 0;
    if (r) begin
      m_phase = 0; m_lives = 0; m_level = 0; m_ticks = 0;
      return;
    end
    case (m_phase)
      0: if (st) begin
           m_phase = 1; m_lives = LIVES; m_level = 1; m_resp = 1;
         end
      1: begin
           m_ticks = 0;
           if (hit) m_phase = 2;
           else if (clr) m_phase = 3;
         end
      2: if (tick) begin
           m_ticks++;
           if (m_ticks == DEATH) begin
             m_ticks = 0;
             if (m_lives == 1) begin
               m_lives = 0; m_phase = 4; m_endg = 1;
             end else begin
               m_lives--; m_phase = 1; m_resp = 1;
             end
           end
         end
      3: if (tick) begin
           m_ticks++;
           if (m_ticks == CLEAR) begin
             m_ticks = 0;
             m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
             m_phase = 1; m_resp = 1;
           end
         end
      default: if (tick) begin
           m_ticks++;
           if (m_ticks == OVER) begin
             m_ticks = 0; m_phase = 0;
           end
         end
    endcase
  endtask

  // driver: inputs change on the falling edge, expectation queued for the next rising edge
  task automatic step(input logic r, input logic st, input logic hit,
                      input logic clr, input logic tick);
    @(negedge clk);
    rst = r; start = st; dug_hit = hit; level_clear = clr; frame_tick = tick;
    model_step(r, st, hit, clr, tick);
    exp_q.push_back(pack_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {phase, freeze, respawn, lives, level, endgame_delay};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got phase=%0d frz=%0b resp=%0b lives=%0d lvl=%0d endg=%0b want phase=%0d frz=%0b resp=%0b lives=%0d lvl=%0d endg=%0b",
                   $time, a[11:9], a[8], a[7], a[6:5], a[4:1], a[0],
                   e[11:9], e[8], e[7], e[6:5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; dug_hit = 1'b0; level_clear = 1'b0; frame_tick = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // ignored inputs in TITLE, then normal start
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // death with respawn, held dug_hit during DYING
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(DEATH);
    idle(2);
    // simultaneous hit and clear, then death down to game over
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(DEATH);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(DEATH);
    idle(1);
    ticks(OVER);
    idle(2);
    // climb to level 15 and one clear beyond
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 15; l++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(CLEAR);
    end
    // reset after 2 of 4 ticks in DYING
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // random play
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0));
    end
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_phase_ctrl.md
GAME_PHASE_CTRL -- requirements
Module: game_phase_ctrl

Interface
REQ-001 Parameter DEATH_FRAMES, default 120, frames spent in DYING before respawn or game over; legal range 1..255.
REQ-002 Parameter CLEAR_FRAMES, default 90, frames spent in CLEAR before the next level; legal range 1..255.
REQ-003 Parameter OVER_FRAMES, default 180, frames spent in OVER before returning to TITLE; legal range 1..255.
REQ-004 Parameter LIVES_INIT, default 3, lives loaded at game start; legal range 1..3.
REQ-005 Clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_tick  input  1  one-Clk-cycle pulse per video frame.
REQ-008 start  input  1  player start request, level-sensitive.
REQ-009 dug_hit  input  1  player collided with an enemy or a rock.
REQ-010 level_clear  input  1  all enemies on the current level eliminated.
REQ-011 phase  output  3  current phase: TITLE=0, PLAY=1, DYING=2, CLEAR=3, OVER=4.
REQ-012 freeze  output  1  high means entity updates are halted.
REQ-013 respawn  output  1  one-cycle pulse telling entity blocks to reload start positions.
REQ-014 lives  output  2  remaining lives.
REQ-015 level  output  4  current level number.
REQ-016 endgame_delay  output  1  one-cycle pulse on the first cycle in OVER.

Function
REQ-017 Five registered states TITLE, PLAY, DYING, CLEAR, OVER; phase SHALL equal the state encoding.
REQ-018 An 8-bit frame timer SHALL clear to 0 on every state change and increment only on frame_tick while in DYING, CLEAR or OVER.
REQ-019 TITLE: start=1 -> PLAY on the next edge, with lives<=LIVES_INIT, level<=1 and respawn=1 for that one cycle.
REQ-020 PLAY: dug_hit=1 -> DYING; else level_clear=1 -> CLEAR; dug_hit SHALL win when both are high in the same cycle.
REQ-021 DYING: on frame_tick with timer==DEATH_FRAMES-1: lives==1 -> OVER with lives<=0; otherwise -> PLAY with lives<=lives-1 and a respawn pulse.
REQ-022 CLEAR: on frame_tick with timer==CLEAR_FRAMES-1 -> PLAY with level<=level+1, saturating at 15, and a respawn pulse.
REQ-023 OVER: on frame_tick with timer==OVER_FRAMES-1 -> TITLE; lives and level SHALL hold their values.
REQ-024 freeze SHALL be 0 only in PLAY, and SHALL be 1 in every other state, including the transition cycle.
REQ-025 respawn and endgame_delay SHALL be registered, glitch-free, and exactly one Clk cycle wide.
REQ-026 start is ignored outside TITLE; dug_hit and level_clear are ignored outside PLAY; frame_tick has no effect in TITLE or PLAY.
REQ-027 A held start or dug_hit SHALL NOT retrigger a transition until the FSM returns to the accepting state.
REQ-028 Latency: every input-triggered transition SHALL be visible on phase one Clk edge after the qualifying input cycle.

Reset
REQ-029 Reset=1 SHALL asynchronously force: state TITLE, timer 0, lives 0, level 0, freeze 1, respawn 0, endgame_delay 0.
REQ-030 Reset asserted mid-DYING, mid-CLEAR or mid-OVER SHALL abort the sequence with no respawn or endgame_delay pulse.
REQ-031 After Reset deasserts, the FSM SHALL wait in TITLE for start.

Verification
REQ-032 Normal start: Reset, then start=1 for 1 cycle -> phase=1, lives=3, level=1, respawn high for 1 cycle, freeze=0.
REQ-033 Death with respawn, DEATH_FRAMES=4, lives=3: dug_hit pulse -> phase=2 and freeze=1; after 4 frame_ticks -> phase=1, lives=2, one respawn pulse.
REQ-034 Final death and game over, OVER_FRAMES=2, lives=1: dug_hit pulse, then 4 ticks -> phase=4, lives=0, endgame_delay for 1 cycle; 2 more ticks -> phase=0.
REQ-035 Simultaneous events and level saturation: dug_hit=1 and level_clear=1 in the same cycle -> phase=2; separately, level=15 and a CLEAR completes -> level stays 15, phase=1.
REQ-036 Reset mid-sequence and ignored inputs: Reset after 2 of 4 ticks in DYING -> phase=0, lives=0, no respawn; dug_hit in TITLE -> phase stays 0.
